// File: rtl/noise_vga_scanout_pkg.sv
// Shared timing defaults, the latency-aligned control bundle and the dither/palette helpers
// used by the VGA noise scan-out.
package noise_vga_pkg;

  localparam int NOISE_LAT = 3;

  localparam int H_ACTIVE     = 640;
  localparam int H_FP         = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BP         = 48;
  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int V_ACTIVE     = 480;
  localparam int V_FP         = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BP         = 33;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic display_on;
    logic h0;
    logic v0;
  } align_t;

  localparam align_t ALIGN_IDLE = '{hsync: 1'b1, vsync: 1'b1, display_on: 1'b0, h0: 1'b0, v0: 1'b0};

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  // 2x2 ordered-dither threshold indexed by the pixel's x/y parity.
  function automatic logic [1:0] bayer_threshold(input logic h0, input logic v0);
    logic [1:0] t;
    case ({h0, v0})
      2'b00:   t = 2'd0;
      2'b10:   t = 2'd2;
      2'b01:   t = 2'd3;
      default: t = 2'd1;
    endcase
    return t;
  endfunction

  // nib = noise[7:4]: upper pair is the coarse level, lower pair the fraction.
  function automatic logic [1:0] dither(input logic [3:0] nib, input logic h0, input logic v0);
    logic [2:0] sum;
    sum = {1'b0, nib[3:2]} + {2'b00, (nib[1:0] > bayer_threshold(h0, v0))};
    return (sum > 3'd3) ? 2'd3 : sum[1:0];
  endfunction

  function automatic rgb_t palette(input logic [1:0] qp);
    rgb_t p;
    p.b = qp;
    p.g = (qp >= 2'd2) ? qp - 2'd1 : 2'd0;
    p.r = (qp == 2'd3) ? 2'd3 : 2'd0;
    return p;
  endfunction

endpackage

// File: rtl/noise_vga_scanout_if.sv
// Coordinate/result bus between the scan-out (master) and the noise generator (slave).
interface noise_vga_scanout_if;
  logic [9:0] noise_x;
  logic [9:0] noise_y;
  logic [7:0] noise_in;

  modport master (output noise_x, output noise_y, input noise_in);
  modport slave  (input noise_x, input noise_y, output noise_in);
endinterface

// File: rtl/noise_vga_scanout_delay_line.sv
// Fixed-depth shift register; every stage resets to rst_val_i so the tap reads a
// known idle value until real data has propagated through.
module scan_delay_line #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rst_val_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= rst_val_i;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/noise_vga_scanout.sv
// VGA scan-out for the noise path: raster counters, coordinate registers, sync/blank
// alignment to the generator latency, and the dithered 2-bit-per-channel output stage.
module noise_vga_scanout
  import noise_vga_pkg::*;
#(
  parameter int HACT = H_ACTIVE,
  parameter int HFP  = H_FP,
  parameter int HSW  = H_SYNC,
  parameter int HBP  = H_BP,
  parameter int VACT = V_ACTIVE,
  parameter int VFP  = V_FP,
  parameter int VSW  = V_SYNC,
  parameter int VBP  = V_BP,
  parameter int LAT  = NOISE_LAT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       scroll_en_i,
  noise_vga_scanout_if.master        noise,
  output logic                       hsync_o,
  output logic                       vsync_o,
  output logic [1:0]                 r_o,
  output logic [1:0]                 g_o,
  output logic [1:0]                 b_o,
  output logic                       frame_start_o,
  output logic [7:0]                 frame_cnt_o
);

  localparam logic [9:0] H_LAST  = 10'(HACT + HFP + HSW + HBP - 1);
  localparam logic [9:0] V_LAST  = 10'(VACT + VFP + VSW + VBP - 1);
  localparam logic [9:0] HS_BEG  = 10'(HACT + HFP);
  localparam logic [9:0] HS_END  = 10'(HACT + HFP + HSW);
  localparam logic [9:0] VS_BEG  = 10'(VACT + VFP);
  localparam logic [9:0] VS_END  = 10'(VACT + VFP + VSW);
  localparam logic [9:0] H_VIS   = 10'(HACT);
  localparam logic [9:0] V_VIS   = 10'(VACT);

  logic [9:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic [9:0] nx_q, nx_d, ny_q;
  logic [7:0] fcnt_q, fcnt_d;
  logic       fstart_q;
  logic       line_end, frame_end;
  align_t     raw_bundle, dly_bundle;
  logic [$bits(align_t)-1:0] dly_bits;
  rgb_t       pix_d, pix_q;
  logic       hsync_q, vsync_q;
  logic       unused_noise_lsb;

  always_comb begin
    line_end  = (hpos_q == H_LAST);
    frame_end = line_end && (vpos_q == V_LAST);
    hpos_d    = line_end ? 10'd0 : hpos_q + 10'd1;
    vpos_d    = vpos_q;
    if (line_end) vpos_d = frame_end ? 10'd0 : vpos_q + 10'd1;
    fcnt_d    = frame_end ? fcnt_q + 8'd1 : fcnt_q;
    // Offset uses the next frame count so the first pixel of a frame already scrolls.
    nx_d      = hpos_d + (scroll_en_i ? {2'b00, fcnt_d} : 10'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q   <= '0;
      vpos_q   <= '0;
      nx_q     <= '0;
      ny_q     <= '0;
      fcnt_q   <= '0;
      fstart_q <= 1'b0;
    end else begin
      hpos_q   <= hpos_d;
      vpos_q   <= vpos_d;
      nx_q     <= nx_d;
      ny_q     <= vpos_d;
      fcnt_q   <= fcnt_d;
      fstart_q <= frame_end;
    end
  end

  always_comb begin
    raw_bundle.hsync      = !((hpos_q >= HS_BEG) && (hpos_q < HS_END));
    raw_bundle.vsync      = !((vpos_q >= VS_BEG) && (vpos_q < VS_END));
    raw_bundle.display_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);
    raw_bundle.h0         = hpos_q[0];
    raw_bundle.v0         = vpos_q[0];
  end

  scan_delay_line #(
    .WIDTH ($bits(align_t)),
    .DEPTH (LAT)
  ) u_align (
    .clk       (clk),
    .rst_n     (rst_n),
    .rst_val_i (ALIGN_IDLE),
    .d_i       (raw_bundle),
    .q_o       (dly_bits)
  );

  assign dly_bundle       = dly_bits;
  assign unused_noise_lsb = ^noise.noise_in[3:0];

  always_comb begin
    pix_d = '0;
    if (dly_bundle.display_on)
      pix_d = palette(dither(noise.noise_in[7:4], dly_bundle.h0, dly_bundle.v0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      pix_q   <= '0;
    end else begin
      hsync_q <= dly_bundle.hsync;
      vsync_q <= dly_bundle.vsync;
      pix_q   <= pix_d;
    end
  end

  assign noise.noise_x = nx_q;
  assign noise.noise_y = ny_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign r_o           = pix_q.r;
  assign g_o           = pix_q.g;
  assign b_o           = pix_q.b;
  assign frame_start_o = fstart_q;
  assign frame_cnt_o   = fcnt_q;

endmodule

// File: tb/tb_noise_vga_scanout.sv
// Scoreboard bench: a full-timing instance and a shrunk-timing instance (for frame-level
// behaviour) share clock and reset; a raster model predicts every output cycle.
module tb_noise_vga_scanout;

  localparam int NI   = 2;
  localparam int PIPE = 4;  // generator latency plus the registered output stage
  localparam int HACT_T [NI] = '{640, 8};
  localparam int HFP_T  [NI] = '{16, 2};
  localparam int HSW_T  [NI] = '{96, 3};
  localparam int HBP_T  [NI] = '{48, 3};
  localparam int VACT_T [NI] = '{480, 4};
  localparam int VFP_T  [NI] = '{10, 1};
  localparam int VSW_T  [NI] = '{2, 2};
  localparam int VBP_T  [NI] = '{33, 1};

  typedef struct {
    int         k;
    logic       hs;
    logic       vs;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       fs;
    logic [7:0] fc;
    logic [9:0] nx;
    logic [9:0] ny;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scroll [NI];
  logic [7:0] nin [NI];
  logic       hs_w [NI], vs_w [NI], fs_w [NI];
  logic [1:0] r_w [NI], g_w [NI], b_w [NI];
  logic [7:0] fc_w [NI];
  logic [9:0] nx_w [NI], ny_w [NI];

  exp_t sb [NI][$];
  int   k;
  int   checks = 0;
  int   passes = 0;
  bit   hs_seen = 1'b0;
  int   hs_hits = 0;

  always #5 clk = ~clk;

  noise_vga_scanout_if nif0 ();
  noise_vga_scanout_if nif1 ();

  assign nif0.noise_in = nin[0];
  assign nif1.noise_in = nin[1];
  assign nx_w[0] = nif0.noise_x;
  assign ny_w[0] = nif0.noise_y;
  assign nx_w[1] = nif1.noise_x;
  assign ny_w[1] = nif1.noise_y;

  noise_vga_scanout dut_full (
    .clk           (clk),
    .rst_n         (rst_n),
    .scroll_en_i   (scroll[0]),
    .noise         (nif0),
    .hsync_o       (hs_w[0]),
    .vsync_o       (vs_w[0]),
    .r_o           (r_w[0]),
    .g_o           (g_w[0]),
    .b_o           (b_w[0]),
    .frame_start_o (fs_w[0]),
    .frame_cnt_o   (fc_w[0])
  );

  noise_vga_scanout #(
    .HACT (HACT_T[1]), .HFP (HFP_T[1]), .HSW (HSW_T[1]), .HBP (HBP_T[1]),
    .VACT (VACT_T[1]), .VFP (VFP_T[1]), .VSW (VSW_T[1]), .VBP (VBP_T[1])
  ) dut_small (
    .clk           (clk),
    .rst_n         (rst_n),
    .scroll_en_i   (scroll[1]),
    .noise         (nif1),
    .hsync_o       (hs_w[1]),
    .vsync_o       (vs_w[1]),
    .r_o           (r_w[1]),
    .g_o           (g_w[1]),
    .b_o           (b_w[1]),
    .frame_start_o (fs_w[1]),
    .frame_cnt_o   (fc_w[1])
  );

  // Expected outputs after the k-th clock edge since reset release; v is the noise value
  // presented just before that edge, s the scroll_en level sampled on it.
  function automatic exp_t model(int i, int kk, logic [7:0] v, logic s);
    exp_t m;
    int ht, vt, fr, n, h, y, t, q, f, qp, frames;
    ht = HACT_T[i] + HFP_T[i] + HSW_T[i] + HBP_T[i];
    vt = VACT_T[i] + VFP_T[i] + VSW_T[i] + VBP_T[i];
    fr = ht * vt;
    m.k = kk; m.hs = 1'b1; m.vs = 1'b1; m.r = 2'd0; m.g = 2'd0; m.b = 2'd0;
    if (kk >= PIPE) begin
      n = kk - PIPE;
      h = n % ht;
      y = (n / ht) % vt;
      m.hs = !(h >= HACT_T[i] + HFP_T[i] && h < HACT_T[i] + HFP_T[i] + HSW_T[i]);
      m.vs = !(y >= VACT_T[i] + VFP_T[i] && y < VACT_T[i] + VFP_T[i] + VSW_T[i]);
      if (h < HACT_T[i] && y < VACT_T[i]) begin
        if (h % 2 == 0 && y % 2 == 0)      t = 0;
        else if (h % 2 == 1 && y % 2 == 0) t = 2;
        else if (h % 2 == 0)               t = 3;
        else                               t = 1;
        q  = int'(v) / 64;
        f  = (int'(v) / 16) % 4;
        qp = q + ((f > t) ? 1 : 0);
        if (qp > 3) qp = 3;
        m.b = 2'(qp);
        m.g = (qp >= 2) ? 2'(qp - 1) : 2'd0;
        m.r = (qp == 3) ? 2'd3 : 2'd0;
      end
    end
    frames = (kk / fr) % 256;
    m.fc = 8'(frames);
    m.fs = (kk > 0) && (kk % fr == 0);
    m.nx = 10'(((kk % ht) + (s ? frames : 0)) % 1024);
    m.ny = 10'((kk / ht) % vt);
    return m;
  endfunction

  task automatic step();
    logic [7:0] v;
    int sel;
    k++;
    if (k == 5 * 128) scroll[1] = 1'b1;
    if ($urandom_range(0, 2999) == 0) scroll[0] = !scroll[0];
    for (int i = 0; i < NI; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      v = 8'h50;
      else if (sel == 1) v = 8'hFF;
      else               v = 8'($urandom);
      nin[i] = v;
      sb[i].push_back(model(i, k, v, scroll[i]));
    end
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({hs_w[i], vs_w[i], r_w[i], g_w[i], b_w[i], fs_w[i], fc_w[i], nx_w[i], ny_w[i]}
          === {1'b1, 1'b1, 6'd0, 1'b0, 8'd0, 10'd0, 10'd0})
        passes++;
      else
        $display("FAIL %s inst%0d got hs=%0b vs=%0b rgb=%0d/%0d/%0d fs=%0b fc=%0d nx=%0d ny=%0d want hs=1 vs=1 rgb=0/0/0 fs=0 fc=0 nx=0 ny=0",
                 tag, i, hs_w[i], vs_w[i], r_w[i], g_w[i], b_w[i], fs_w[i], fc_w[i], nx_w[i], ny_w[i]);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    k       = 0;
    hs_seen = 1'b0;
    step();
  endtask

  // Monitor: one popped expectation per instance per clock edge.
  initial begin
    exp_t e;
    logic [36:0] act, want;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (sb[i].size() > 0) begin
          e    = sb[i].pop_front();
          act  = {hs_w[i], vs_w[i], r_w[i], g_w[i], b_w[i], fs_w[i], fc_w[i], nx_w[i], ny_w[i]};
          want = {e.hs, e.vs, e.r, e.g, e.b, e.fs, e.fc, e.nx, e.ny};
          checks++;
          if (act === want) passes++;
          else
            $display("FAIL pixel inst%0d k=%0d got hs=%0b vs=%0b rgb=%0d/%0d/%0d fs=%0b fc=%0d nx=%0d ny=%0d want hs=%0b vs=%0b rgb=%0d/%0d/%0d fs=%0b fc=%0d nx=%0d ny=%0d",
                     i, e.k, hs_w[i], vs_w[i], r_w[i], g_w[i], b_w[i], fs_w[i], fc_w[i], nx_w[i], ny_w[i],
                     e.hs, e.vs, e.r, e.g, e.b, e.fs, e.fc, e.nx, e.ny);
          if (i == 0 && !hs_seen && hs_w[0] === 1'b0) begin
            hs_seen = 1'b1;
            hs_hits++;
            checks++;
            if (e.k == 656 + 3 + 1) passes++;
            else $display("FAIL first_hsync got clocks=%0d want %0d", e.k, 656 + 3 + 1);
          end
        end
      end
    end
  end

  initial begin
    scroll[0] = 1'b0;
    scroll[1] = 1'b0;
    nin[0]    = 8'h00;
    nin[1]    = 8'h00;
    k         = 0;
    repeat (3) @(negedge clk);
    check_reset("reset_hold");

    release_reset();
    repeat (260 * 128 + 500) begin
      @(negedge clk);
      step();
    end

    // Mid-line reset when the full-timing raster sits at hpos=300.
    for (int n = 0; n < 800 && (k % 800) != 300; n++) begin
      @(negedge clk);
      step();
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("midline_async");
    repeat (5) @(negedge clk);
    check_reset("midline_hold");

    release_reset();
    repeat (2000) begin
      @(negedge clk);
      step();
    end

    @(posedge clk);
    #3;
    checks++;
    if (sb[0].size() == 0 && sb[1].size() == 0) passes++;
    else $display("FAIL drain got pending=%0d/%0d want 0/0", sb[0].size(), sb[1].size());
    checks++;
    if (hs_hits == 2) passes++;
    else $display("FAIL hsync_seen got %0d want 2", hs_hits);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
